// File: rtl/aes128_iter_ctrl_if.sv
// Handshake and data bundle between a block source/consumer and aes128_iter_ctrl.
// The master side offers plaintext/key pairs and takes ciphertexts.
interface aes128_iter_ctrl_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;
  logic [3:0]   round;

  modport master (
    output in_valid, in_state, in_key, out_ready,
    input  in_ready, out_valid, out_state, busy, round
  );

  modport slave (
    input  in_valid, in_state, in_key, out_ready,
    output in_ready, out_valid, out_state, busy, round
  );
endinterface

// File: rtl/aes128_iter_ctrl.sv
// Iterative AES-128 encryptor: one combinational round datapath reused for rounds 1..10,
// with state/key registers, round counter, Rcon generation and valid/ready handshakes.
module aes128_iter_ctrl (
  input  logic                 clk,
  input  logic                 rst,
  aes128_iter_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_t;

  fsm_t         fsm_reg, fsm_next;
  logic [127:0] state_reg;
  logic [127:0] key_reg;
  logic [127:0] out_reg;
  logic [7:0]   rcon_reg;
  logic [3:0]   round_reg;

  logic [127:0] sub_bytes;
  logic [127:0] shifted;
  logic [127:0] mixed;
  logic [127:0] next_key;
  logic [127:0] round_out;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box as multiplicative inverse (x^254, so 0 maps to 0) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] base;
    logic [7:0] e;
    inv  = 8'h01;
    base = x;
    e    = 8'hfe;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) inv = gf_mul(inv, base);
      base = gf_mul(base, base);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Byte k sits at [127-8k -: 8]; row r / column c is byte r+4c.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [127:0] key_schedule(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w3;
    logic [31:0] t;
    logic [31:0] n0, n1, n2, n3;
    w3 = k[31:0];
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  for (genvar gi = 0; gi < 16; gi++) begin : g_sbox
    assign sub_bytes[127-8*gi -: 8] = sbox(state_reg[127-8*gi -: 8]);
  end

  assign shifted   = shift_rows(sub_bytes);
  assign mixed     = mix_columns(shifted);
  assign next_key  = key_schedule(key_reg, rcon_reg);
  // The last round skips MixColumns.
  assign round_out = ((fsm_reg == FINAL) ? shifted : mixed) ^ next_key;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fsm_reg <= IDLE;
    else     fsm_reg <= fsm_next;
  end

  always_comb begin
    fsm_next      = fsm_reg;
    bus.in_ready  = (fsm_reg == IDLE) && !rst;
    bus.out_valid = (fsm_reg == DONE);
    bus.busy      = (fsm_reg == ROUND) || (fsm_reg == FINAL);
    bus.round     = round_reg;
    bus.out_state = out_reg;
    case (fsm_reg)
      IDLE:    if (bus.in_valid) fsm_next = ROUND;
      ROUND:   if (round_reg == 4'd9) fsm_next = FINAL;
      FINAL:   fsm_next = DONE;
      DONE:    if (bus.out_ready) fsm_next = IDLE;
      default: fsm_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= '0;
      key_reg   <= '0;
      out_reg   <= '0;
      rcon_reg  <= 8'h01;
      round_reg <= 4'd0;
    end else begin
      case (fsm_reg)
        IDLE: begin
          if (bus.in_valid) begin
            state_reg <= bus.in_state ^ bus.in_key;
            key_reg   <= bus.in_key;
            rcon_reg  <= 8'h01;
            round_reg <= 4'd1;
          end
        end
        ROUND: begin
          state_reg <= round_out;
          key_reg   <= next_key;
          rcon_reg  <= xtime(rcon_reg);
          round_reg <= round_reg + 4'd1;
        end
        FINAL: begin
          state_reg <= round_out;
          key_reg   <= next_key;
          rcon_reg  <= xtime(rcon_reg);
          out_reg   <= round_out;
          round_reg <= 4'd0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_iter_ctrl.sv
// Self-checking bench for aes128_iter_ctrl: known-answer table, handshake corner cases,
// and random blocks checked against a byte-array AES-128 reference model.
module tb_aes128_iter_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes128_iter_ctrl_if bus();

  aes128_iter_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int cmp_count = 0;
  int err_count = 0;

  logic [7:0] sbox_tab [256];

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  vec_t vecs [3];

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    cmp_count++;
    if (act !== exp) begin
      err_count++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] dbl(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box table built by walking generator 3 and its inverse 3^-1 over GF(2^8).
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    for (int n = 0; n < 255; n++) begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_tab[p] = x ^ 8'h63;
    end
    sbox_tab[0] = 8'h63;
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [7:0]   st [16];
    logic [7:0]   tmp [16];
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [31:0]  t;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]} ^ {rc, 24'h0};
        rc = dbl(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k < 16; k++) st[k] = pt[127-8*k -: 8] ^ w[k/4][31-8*(k%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int k = 0; k < 16; k++) tmp[k] = sbox_tab[st[k]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          st[row+4*c] = tmp[row+4*((c+row)%4)];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
          st[4*c]   = dbl(a0) ^ dbl(a1) ^ a1 ^ a2 ^ a3;
          st[4*c+1] = a0 ^ dbl(a1) ^ dbl(a2) ^ a2 ^ a3;
          st[4*c+2] = a0 ^ a1 ^ dbl(a2) ^ dbl(a3) ^ a3;
          st[4*c+3] = dbl(a0) ^ a0 ^ a1 ^ a2 ^ dbl(a3);
        end
      end
      for (int k = 0; k < 16; k++) st[k] = st[k] ^ w[4*r + k/4][31-8*(k%4) -: 8];
    end
    for (int k = 0; k < 16; k++) res[127-8*k -: 8] = st[k];
    return res;
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30) check("in_ready_timeout", 0, 1);
  endtask

  task automatic run_block(input string tag, input logic [127:0] key, input logic [127:0] pt,
                           input logic [127:0] exp, input int stall, input bit scramble);
    int j;
    wait_ready();
    bus.in_valid = 1'b1;
    bus.in_key   = key;
    bus.in_state = pt;
    @(negedge clk);
    bus.in_valid = 1'b0;
    j = 0;
    while (bus.out_valid !== 1'b1 && j < 20) begin
      if (j < 10) begin
        check({tag, "_round"}, bus.round, j + 1);
        check({tag, "_busy"}, bus.busy, 1);
      end
      if (scramble) begin
        bus.in_state = {$urandom, $urandom, $urandom, $urandom};
        bus.in_key   = {$urandom, $urandom, $urandom, $urandom};
        bus.in_valid = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      j++;
    end
    bus.in_valid = 1'b0;
    check({tag, "_latency"}, j, 10);
    check({tag, "_out_state"}, bus.out_state, exp);
    check({tag, "_round_done"}, bus.round, 0);
    for (int s = 0; s < stall; s++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      check({tag, "_hold_state"}, bus.out_state, exp);
      check({tag, "_hold_in_ready"}, bus.in_ready, 0);
      check({tag, "_hold_out_valid"}, bus.out_valid, 1);
    end
    // in_valid may be high during the output handshake; it must not be accepted there.
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'($urandom_range(0, 1));
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check({tag, "_idle_in_ready"}, bus.in_ready, 1);
    check({tag, "_idle_out_valid"}, bus.out_valid, 0);
    check({tag, "_idle_busy"}, bus.busy, 0);
    check({tag, "_kept_state"}, bus.out_state, exp);
  endtask

  initial begin
    int n, seen, n_acc;
    int acc_t [2];
    logic [127:0] outs [$];
    logic [127:0] rk, rp;

    build_sbox();
    vecs[0] = '{C1_KEY, C1_PT, C1_CT};
    vecs[1] = '{B_KEY, B_PT, B_CT};
    vecs[2] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_state  = '0;
    bus.in_key    = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_round", bus.round, 0);
    check("rst_out_state", bus.out_state, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", bus.in_ready, 1);

    for (int i = 0; i < 3; i++) begin
      run_block($sformatf("kat%0d", i), vecs[i].key, vecs[i].pt, vecs[i].ct, 0, 1'b0);
      $display("kat%0d: key %h pt %h out %h", i, vecs[i].key, vecs[i].pt, bus.out_state);
    end

    run_block("backpressure", C1_KEY, C1_PT, C1_CT, 5, 1'b0);
    $display("backpressure: out %h", bus.out_state);
    run_block("stability", C1_KEY, C1_PT, C1_CT, 1, 1'b1);
    $display("stability: out %h", bus.out_state);

    // Abort a block at round 5 with an asynchronous reset.
    wait_ready();
    bus.in_valid = 1'b1;
    bus.in_key   = B_KEY;
    bus.in_state = B_PT;
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 0;
    while (bus.round !== 4'd5 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("abort_reach_round5", bus.round, 5);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_round", bus.round, 0);
    check("abort_in_ready", bus.in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      if (bus.out_valid === 1'b1 || bus.busy === 1'b1) seen++;
      @(negedge clk);
    end
    check("abort_no_output", seen, 0);
    $display("abort: reset applied at round 5");
    run_block("after_abort", C1_KEY, C1_PT, C1_CT, 0, 1'b0);
    $display("after_abort: out %h", bus.out_state);

    // Back-to-back with in_valid held and out_ready held.
    wait_ready();
    bus.in_valid  = 1'b1;
    bus.in_key    = C1_KEY;
    bus.in_state  = C1_PT;
    bus.out_ready = 1'b1;
    n_acc = 0;
    acc_t[0] = 0;
    acc_t[1] = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1 && n_acc < 2) begin
        acc_t[n_acc] = c;
        n_acc++;
      end
      if (bus.out_valid === 1'b1) outs.push_back(bus.out_state);
      @(negedge clk);
      if (n_acc == 1) begin
        bus.in_key   = B_KEY;
        bus.in_state = B_PT;
      end
      if (n_acc == 2) bus.in_valid = 1'b0;
    end
    bus.out_ready = 1'b0;
    check("b2b_accepts", n_acc, 2);
    check("b2b_spacing", acc_t[1] - acc_t[0], 12);
    check("b2b_out_count", outs.size(), 2);
    if (outs.size() >= 2) begin
      check("b2b_first", outs[0], C1_CT);
      check("b2b_second", outs[1], B_CT);
    end
    $display("b2b: accepts %0d spacing %0d outputs %0d", n_acc, acc_t[1] - acc_t[0], outs.size());

    for (int i = 0; i < 10; i++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      rp = {$urandom, $urandom, $urandom, $urandom};
      run_block($sformatf("rand%0d", i), rk, rp, aes_ref(rk, rp), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      $display("rand%0d: key %h pt %h out %h", i, rk, rp, bus.out_state);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule
